// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: autonomous request-side controller for the ADC capture core.
// It scans the channels in a latched mask in ascending order, presenting each
// channel 2^AVG_LOG2 times followed by one flush frame. Every result belongs to
// the address acked one frame earlier. Results are averaged and stored in a
// per-channel bank.
//
// Ports:
//   clk25, rst         clock, asynchronous active-high reset
//   start, continuous  one-shot scan request / automatic rescan after SCAN_GAP
//   ch_mask            enabled channels (bit i = channel i), latched per scan
//   cap_en/ack/addr    request side of the capture core
//   cap_ready/data     conversion handshake level and result from the core
//   rd_addr/rd_data    combinational read of the averaged-result bank
//   ch_valid           channel i holds a result since reset
//   busy, scan_done    not idle / pulse on the scan's final bank write
//   err_timeout        sticky: no cap_ready edge within TIMEOUT cycles
module adc_scan_sequencer #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SCAN_GAP = 25000,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  output logic        cap_en,
  output logic        cap_ack,
  output logic [2:0]  cap_addr,
  input  logic        cap_ready,
  input  logic [11:0] cap_data,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic [7:0]  ch_valid,
  output logic        busy,
  output logic        scan_done,
  output logic        err_timeout
);

  localparam int unsigned NCH   = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 12;
  localparam int unsigned ACC_W = DW + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned REPS  = 1 << AVG_LOG2;
  localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cap_en_q, cap_en_d;
  logic              cap_ack_q, cap_ack_d;
  logic [AW-1:0]     cap_addr_q, cap_addr_d;
  logic [NCH-1:0]    scan_mask_q, scan_mask_d;
  logic [AW-1:0]     pipe_addr_q, pipe_addr_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ready_q, ready_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DW-1:0]     bank_q [NCH];
  logic [DW-1:0]     bank_d [NCH];
  logic [NCH-1:0]    ch_valid_q, ch_valid_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic              err_q, err_d;

  logic              launch;
  logic [AW:0]       pick;
  logic [ACC_W-1:0]  acc_sum;

  // Lowest set bit of m at index >= from; returns {found, index}.
  function automatic logic [AW:0] first_above(input logic [NCH-1:0] m,
                                               input logic [AW:0]    from);
    logic [AW:0] r;
    r = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!r[AW] && m[i] && ((AW+1)'(i) >= from)) r = {1'b1, AW'(i)};
    end
    return r;
  endfunction

  // Next-state, scan plan, averaging and timeout logic.
  always_comb begin
    state_d      = state_q;
    cap_addr_d   = cap_addr_q;
    scan_mask_d  = scan_mask_q;
    pipe_addr_d  = pipe_addr_q;
    pipe_valid_d = pipe_valid_q;
    flush_d      = flush_q;
    rep_d        = rep_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    ready_d      = cap_ready;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    bank_d       = bank_q;
    ch_valid_d   = ch_valid_q;
    err_d        = err_q;
    scan_done_d  = 1'b0;
    launch       = 1'b0;
    pick         = '0;
    // First credited sample of a channel restarts the accumulator.
    acc_sum      = (cnt_q == '0) ? ACC_W'(cap_data) : acc_q + ACC_W'(cap_data);

    case (state_q)
      S_IDLE: begin
        if ((start || (continuous && !err_q)) && (ch_mask != '0)) launch = 1'b1;
      end
      S_RUN: begin
        if (cap_ack_q) begin
          tmo_d = TMO_W'(1);
          // Data in this ack cycle belongs to the address acked previously.
          if (pipe_valid_q) begin
            acc_d = acc_sum;
            if (cnt_q == CNT_W'(REPS - 1)) begin
              bank_d[pipe_addr_q]     = DW'(acc_sum >> AVG_LOG2);
              ch_valid_d[pipe_addr_q] = 1'b1;
              cnt_d                   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          pipe_addr_d  = cap_addr_q;
          pipe_valid_d = 1'b1;
          if (flush_q) begin
            scan_done_d = 1'b1;
            gap_d       = '0;
            state_d     = continuous ? S_GAP : S_IDLE;
          end else if (rep_q != CNT_W'(REPS - 1)) begin
            rep_d = rep_q + CNT_W'(1);
          end else begin
            rep_d = '0;
            pick  = first_above(scan_mask_q, {1'b0, cap_addr_q} + (AW+1)'(1));
            // No channel left: one more frame on the same address flushes the pipe.
            if (pick[AW]) cap_addr_d = pick[AW-1:0];
            else          flush_d    = 1'b1;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(SCAN_GAP - 1)) begin
          if (continuous && (ch_mask != '0)) launch  = 1'b1;
          else                               state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      pick         = first_above(ch_mask, '0);
      scan_mask_d  = ch_mask;
      cap_addr_d   = pick[AW-1:0];
      pipe_valid_d = 1'b0;
      flush_d      = 1'b0;
      rep_d        = '0;
      cnt_d        = '0;
      tmo_d        = TMO_W'(1);
      state_d      = S_RUN;
    end

    // Rising edge of cap_ready is acked next cycle unless the scan is ending.
    cap_ack_d = (state_q == S_RUN) && (state_d == S_RUN) && cap_ready && !ready_q;
    cap_en_d  = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cap_en_q     <= 1'b0;
      cap_ack_q    <= 1'b0;
      cap_addr_q   <= '0;
      scan_mask_q  <= '0;
      pipe_addr_q  <= '0;
      pipe_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      rep_q        <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      ready_q      <= 1'b0;
      tmo_q        <= '0;
      gap_q        <= '0;
      for (int i = 0; i < int'(NCH); i++) bank_q[i] <= '0;
      ch_valid_q   <= '0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_en_q     <= cap_en_d;
      cap_ack_q    <= cap_ack_d;
      cap_addr_q   <= cap_addr_d;
      scan_mask_q  <= scan_mask_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_valid_q <= pipe_valid_d;
      flush_q      <= flush_d;
      rep_q        <= rep_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      ready_q      <= ready_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      bank_q       <= bank_d;
      ch_valid_q   <= ch_valid_d;
      busy_q       <= busy_d;
      scan_done_q  <= scan_done_d;
      err_q        <= err_d;
    end
  end

  assign cap_en      = cap_en_q;
  assign cap_ack     = cap_ack_q;
  assign cap_addr    = cap_addr_q;
  assign ch_valid    = ch_valid_q;
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign err_timeout = err_q;
  assign rd_data     = bank_q[rd_addr];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: a randomized capture-core model drives the
// handshake, the expected ack address list and per-scan bank snapshots are
// queued, and a monitor compares them as the DUT acks and finishes scans.
module tb_adc_scan_sequencer;

  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned REPS     = 1 << AVG_LOG2;
  localparam int unsigned SCAN_GAP = 100;
  localparam int unsigned TIMEOUT  = 200;

  logic        clk25 = 1'b0;
  logic        rst, start, continuous;
  logic [7:0]  ch_mask;
  logic        cap_en, cap_ack;
  logic [2:0]  cap_addr;
  logic        cap_ready;
  logic [11:0] cap_data;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic [7:0]  ch_valid;
  logic        busy, scan_done, err_timeout;

  adc_scan_sequencer #(.AVG_LOG2(AVG_LOG2), .SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk25(clk25), .rst(rst), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .cap_en(cap_en), .cap_ack(cap_ack), .cap_addr(cap_addr), .cap_ready(cap_ready),
    .cap_data(cap_data), .rd_addr(rd_addr), .rd_data(rd_data), .ch_valid(ch_valid),
    .busy(busy), .scan_done(scan_done), .err_timeout(err_timeout)
  );

  always #20 clk25 = ~clk25;

  typedef struct packed { logic [2:0] addr; logic last; } plan_t;
  typedef struct packed { logic [7:0][11:0] bank; logic [7:0] valid; } snap_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  int ack_count = 0, done_count = 0, last_ack_cyc = 0;
  logic [2:0] mon_addr_q[$];
  plan_t      core_plan_q[$];
  snap_t      done_q[$];
  int         dir_data[$];
  logic [7:0][11:0] exp_bank = '0;
  logic [7:0] exp_valid = '0;
  int  ref_sum[8];
  int  ref_n[8];
  bit  prev_valid = 0;
  logic [2:0] prev_ch = '0;
  bit  stall = 0;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plan: each enabled channel REPS times in ascending order, then a flush frame.
  task automatic push_plan(input logic [7:0] m);
    logic [2:0] last_ch;
    plan_t p;
    last_ch = '0;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (int r = 0; r < int'(REPS); r++) begin
          mon_addr_q.push_back(3'(c));
          p.addr = 3'(c); p.last = 1'b0;
          core_plan_q.push_back(p);
        end
        last_ch = 3'(c);
      end
    end
    mon_addr_q.push_back(last_ch);
    p.addr = last_ch; p.last = 1'b1;
    core_plan_q.push_back(p);
  endtask

  task automatic clear_ref();
    mon_addr_q.delete();
    core_plan_q.delete();
    for (int i = 0; i < 8; i++) begin ref_sum[i] = 0; ref_n[i] = 0; end
    prev_valid = 0;
  endtask

  // Reference for one completed core frame carrying data d.
  task automatic core_ack(input logic [11:0] d);
    plan_t e;
    snap_t s;
    if (core_plan_q.size() == 0) return;
    if (prev_valid) begin
      ref_sum[prev_ch] += int'(d);
      ref_n[prev_ch]++;
      if (ref_n[prev_ch] == int'(REPS)) begin
        exp_bank[prev_ch]  = 12'(ref_sum[prev_ch] / int'(REPS));
        exp_valid[prev_ch] = 1'b1;
        ref_sum[prev_ch]   = 0;
        ref_n[prev_ch]     = 0;
      end
    end
    e = core_plan_q.pop_front();
    prev_ch = e.addr;
    prev_valid = 1;
    if (e.last) begin
      s.bank = exp_bank; s.valid = exp_valid;
      done_q.push_back(s);
      prev_valid = 0;
      if (continuous && ch_mask != 8'h00) push_plan(ch_mask);
    end
  endtask

  // Capture-core model: random latency, ready held until acked, then dropped.
  initial begin : core
    int delay;
    bit drop;
    cap_ready = 1'b0; cap_data = '0; delay = 1; drop = 0;
    forever begin
      @(posedge clk25); #2;
      if (rst || !cap_en) begin
        cap_ready = 1'b0; drop = 0; delay = $urandom_range(1, 3);
      end else if (drop) begin
        cap_ready = 1'b0; drop = 0; delay = $urandom_range(0, 3);
      end else if (cap_ready) begin
        if (cap_ack) begin core_ack(cap_data); drop = 1; end
      end else if (!stall) begin
        if (delay == 0) begin
          if (dir_data.size() > 0) cap_data = 12'(dir_data.pop_front());
          else                     cap_data = 12'($urandom_range(0, 4095));
          cap_ready = 1'b1;
        end else delay--;
      end
    end
  end

  // Monitor: ack addresses and end-of-scan bank contents against the queues.
  initial begin : monitor
    bit prev_done;
    logic [2:0] ea;
    snap_t s;
    prev_done = 0;
    forever begin
      @(negedge clk25);
      if (rst) prev_done = 0;
      else begin
        if (cap_ack) begin
          ack_count++;
          last_ack_cyc = cyc;
          if (mon_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: cap_addr=%0d with no planned frame", cap_addr);
          end else begin
            ea = mon_addr_q.pop_front();
            check("cap_addr", 32'(cap_addr), 32'(ea));
          end
        end
        if (scan_done) begin
          done_count++;
          check("scan_done_one_cycle", 32'(prev_done), 32'(0));
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_scan_done: no scan was expected to end");
          end else begin
            s = done_q.pop_front();
            check("ch_valid", 32'(ch_valid), 32'(s.valid));
            for (int i = 0; i < 8; i++) begin
              rd_addr = 3'(i); #1;
              check($sformatf("bank[%0d]", i), 32'(rd_data), 32'(s.bank[i]));
            end
          end
        end
        prev_done = scan_done;
      end
    end
  end

  task automatic tick(); @(posedge clk25); #1; endtask

  task automatic do_start(input logic [7:0] m);
    tick();
    ch_mask = m;
    if (m != 8'h00) push_plan(m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (done_count < n && t < budget) begin tick(); t++; end
    check("scan_completed", 32'(done_count), 32'(n));
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t = 0;
    while (ack_count < n && t < budget) begin tick(); t++; end
    check("acks_reached", 32'(ack_count >= n), 32'(1));
  endtask

  task automatic idle_for(input string name, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin tick(); if (busy || cap_en) hits++; end
    check(name, 32'(hits), 32'(0));
  endtask

  task automatic wait_en(input logic lvl, input string name);
    int t = 0;
    while (cap_en !== lvl && t < 2000) begin @(negedge clk25); t++; end
    check(name, 32'(cap_en), 32'(lvl));
  endtask

  task automatic check_bank_now(input string name);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #1;
      check($sformatf("%s[%0d]", name, i), 32'(rd_data), 32'(exp_bank[i]));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0, d0, lows;
    logic [7:0] m;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = '0; rd_addr = '0;
    clear_ref();
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    check("rst_cap_en", 32'(cap_en), 0);
    check("rst_cap_ack", 32'(cap_ack), 0);
    check("rst_cap_addr", 32'(cap_addr), 0);
    check("rst_ch_valid", 32'(ch_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    check("rst_err", 32'(err_timeout), 0);
    tick();
    check_bank_now("rst_bank");
    rst = 1'b0;

    // Averaging with known data: first frame discarded, (10+20+30+41)>>2 = 25.
    dir_data = {7, 10, 20, 30, 41};
    a0 = ack_count; d0 = done_count;
    do_start(8'h01);
    wait_done(d0 + 1, 1000);
    check("avg_acks", 32'(ack_count - a0), 32'(5));
    tick();
    rd_addr = 3'd0; #1;
    check("avg_ch0", 32'(rd_data), 32'(25));
    check("avg_busy_after", 32'(busy), 0);

    // Mask change and start pulse mid-scan are ignored.
    a0 = ack_count; d0 = done_count;
    do_start(8'h05);
    wait_acks(a0 + 3, 500);
    ch_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, 1000);
    check("mask05_acks", 32'(ack_count - a0), 32'(2 * REPS + 1));
    idle_for("no_extra_scan", 40);
    check("no_extra_done", 32'(done_count), 32'(d0 + 1));

    // Full eight-channel scan.
    a0 = ack_count; d0 = done_count;
    do_start(8'hFF);
    wait_done(d0 + 1, 2000);
    check("full_scan_acks", 32'(ack_count - a0), 32'(33));

    // Random masks.
    for (int k = 0; k < 4; k++) begin
      m = 8'($urandom_range(1, 255));
      d0 = done_count;
      do_start(m);
      wait_done(d0 + 1, 2000);
    end

    // Empty mask: no activity.
    a0 = ack_count;
    do_start(8'h00);
    idle_for("empty_mask_idle", 20);
    check("empty_mask_acks", 32'(ack_count - a0), 0);

    // Continuous mode: gap length, then drop continuous mid-scan.
    tick();
    ch_mask = 8'h80;
    push_plan(8'h80);
    continuous = 1'b1;
    for (int g = 0; g < 2; g++) begin
      wait_en(1'b1, "cont_scan_running");
      wait_en(1'b0, "cont_scan_ended");
      lows = 0;
      while (cap_en === 1'b0 && lows < 1000) begin @(negedge clk25); lows++; end
      check("gap_cycles", 32'(lows), 32'(SCAN_GAP));
    end
    tick();
    a0 = ack_count; d0 = done_count;
    wait_acks(a0 + 2, 500);
    continuous = 1'b0;
    wait_done(d0 + 1, 1000);
    idle_for("cont_dropped_idle", 150);
    check("cont_dropped_done", 32'(done_count), 32'(d0 + 1));

    // Timeout: core stops answering mid-scan.
    a0 = ack_count;
    do_start(8'h0F);
    wait_acks(a0 + 6, 500);
    stall = 1;
    lows = 0;
    while (err_timeout !== 1'b1 && lows < 1000) begin @(negedge clk25); lows++; end
    check("timeout_err", 32'(err_timeout), 1);
    check("timeout_cycles", 32'(cyc - last_ack_cyc), 32'(TIMEOUT));
    check("timeout_cap_en", 32'(cap_en), 0);
    check("timeout_busy", 32'(busy), 0);
    clear_ref();
    tick();
    check("timeout_ch_valid", 32'(ch_valid), 32'(exp_valid));
    check_bank_now("timeout_bank");
    stall = 0;
    continuous = 1'b1;
    idle_for("timeout_blocks_continuous", 300);
    continuous = 1'b0;
    d0 = done_count;
    do_start(8'h02);
    wait_done(d0 + 1, 1000);
    check("err_sticky", 32'(err_timeout), 1);

    // Asynchronous reset mid-scan, then a fresh scan from the discard frame.
    a0 = ack_count;
    do_start(8'h3C);
    wait_acks(a0 + 5, 500);
    @(posedge clk25); #5;
    rst = 1'b1;
    #1;
    check("arst_cap_en", 32'(cap_en), 0);
    check("arst_cap_ack", 32'(cap_ack), 0);
    check("arst_cap_addr", 32'(cap_addr), 0);
    check("arst_ch_valid", 32'(ch_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(err_timeout), 0);
    clear_ref();
    done_q.delete();
    exp_bank = '0; exp_valid = '0;
    check_bank_now("arst_bank");
    repeat (2) @(posedge clk25);
    #1 rst = 1'b0;
    a0 = ack_count; d0 = done_count;
    do_start(8'h03);
    wait_done(d0 + 1, 1000);
    check("post_rst_acks", 32'(ack_count - a0), 32'(2 * REPS + 1));

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
